// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sequence generator: FSM state encoding
// and the default pattern transmitted when the top is not overridden.
package seqgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } seqgen_state_e;

  localparam logic [3:0] DEFAULT_SEQUENCE   = 4'b1011;
  localparam int         DEFAULT_SEQ_LENGTH = 4;

endpackage

// File: rtl/sequence_generator.sv
// Serial transmitter: sends SEQUENCE MSB-first repeat_count times back-to-back.
// Define SEQGEN_PARITY_EN to append an even-parity bit after every sequence.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int                    SEQ_LENGTH = DEFAULT_SEQ_LENGTH,
  parameter logic [SEQ_LENGTH-1:0] SEQUENCE   = DEFAULT_SEQUENCE,
  parameter int                    REPEAT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [REPEAT_W-1:0] repeat_count,
  output logic                output_bit,
  output logic                bit_valid,
  output logic                busy,
  output logic                done
);

  localparam int                IDX_W    = $clog2(SEQ_LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LENGTH - 1);
`ifdef SEQGEN_PARITY_EN
  localparam logic PARITY_BIT = ^SEQUENCE;
`endif

  seqgen_state_e       state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [REPEAT_W-1:0] cnt_q, cnt_d;
  logic [REPEAT_W-1:0] cnt_dec;
  logic                bit_q, bit_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  assign cnt_dec = cnt_q - REPEAT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are registered decodes of the current state, so each one
  // appears one cycle after the state that produces it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bit_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (repeat_count != '0) begin
            state_d = S_SEND;
            cnt_d   = repeat_count;
            idx_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        vld_d = 1'b1;
        bit_d = SEQUENCE[LAST_IDX - idx_q];
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          cnt_d = cnt_dec;
`ifdef SEQGEN_PARITY_EN
          state_d = S_PARITY;
`else
          if (cnt_dec == '0) state_d = S_DONE;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_PARITY: begin
`ifdef SEQGEN_PARITY_EN
        vld_d   = 1'b1;
        bit_d   = PARITY_BIT;
        state_d = (cnt_q != '0) ? S_SEND : S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = vld_d;
  end

  assign output_bit = bit_q;
  assign bit_valid  = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter SEQUENCE, default 4'b1011; the bit pattern to transmit.
REQ-002 SHALL have parameter SEQ_LENGTH, default 4; the width of SEQUENCE in bits, legal range 2..16.
REQ-003 SHALL have parameter REPEAT_W, default 4; the width of repeat_count.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit; a request to begin transmission, sampled only in S_IDLE.
REQ-007 SHALL have port repeat_count, input, REPEAT_W bits; the number of back-to-back sequences, latched with start.
REQ-008 SHALL have port output_bit, output, 1 bit; the serial data bit, registered.
REQ-009 SHALL have port bit_valid, output, 1 bit; high when output_bit carries a transmitted bit, registered.
REQ-010 SHALL have port busy, output, 1 bit; high while a transmission is in progress.
REQ-011 SHALL have port done, output, 1 bit; a one-cycle completion pulse.

Function
REQ-012 SHALL implement states S_IDLE, S_SEND, S_PARITY and S_DONE.
REQ-013 SHALL move S_IDLE->S_SEND on start=1 with repeat_count!=0, latching repeat_count and clearing the bit index.
REQ-014 SHALL move S_IDLE->S_DONE on start=1 with repeat_count==0, with no bit_valid asserted.
REQ-015 SHALL, when start is sampled at edge T, present the first bit at T+1; bits are sent MSB first (SEQUENCE[SEQ_LENGTH-1] first) with one bit per cycle and no gaps.
REQ-016 SHALL, in S_SEND, drive bit_valid=1 and output_bit=SEQUENCE[SEQ_LENGTH-1-idx], incrementing idx each cycle.
REQ-017 SHALL, on the last bit, wrap idx to 0 and decrement the remaining count; go to S_PARITY if the parity bit is compiled in, else stay in S_SEND while count>0, else go to S_DONE.
REQ-018 SHALL, from S_PARITY, return to S_SEND while count>0, else go to S_DONE.
REQ-019 SHALL, in S_DONE, pulse done=1 for exactly one cycle, drive bit_valid=0 and busy=0, then go to S_IDLE.
REQ-020 SHALL hold busy=1 exactly on the cycles bit_valid=1, including parity cycles.
REQ-021 SHALL ignore start while not in S_IDLE; no queuing, and the latched count is unaffected.
REQ-022 SHALL drive output_bit=0 whenever bit_valid=0.
REQ-023 SHALL, for repeat_count=N, produce exactly N*SEQ_LENGTH valid bits, plus N parity bits when parity is enabled.
REQ-024 SHALL use SEQ_LENGTH-bit modular increment for idx (width clog2(SEQ_LENGTH)) and REPEAT_W-bit arithmetic for the remaining count, with no overflow possible.

Reset
REQ-025 SHALL, on reset=1, immediately and asynchronously force the state to S_IDLE, idx=0, count=0, output_bit=0, bit_valid=0, busy=0 and done=0.
REQ-026 SHALL, on reset asserted mid-transmission, abort the transmission with no done pulse; the first start after release begins a fresh sequence from its MSB.
REQ-027 SHALL accept start on the first clock edge after reset deasserts.

Configuration
REQ-028 SHALL use macro SEQGEN_PARITY_EN: when defined, S_PARITY exists and one even-parity bit (XOR of SEQUENCE) follows each sequence with bit_valid=1.
REQ-029 SHALL, without SEQGEN_PARITY_EN, make S_PARITY unreachable, send sequences back-to-back, and generate no parity logic.

Structure
REQ-030 SHALL place the state enum, DEFAULT_SEQUENCE=4'b1011 and DEFAULT_SEQ_LENGTH=4 in the shared package seqgen_pkg.
REQ-031 SHALL have no sub-module; the bit-index and repeat counters are inline. The module SHALL be a single file.

Verification
REQ-032 SHALL verify: start at T with repeat_count=1 -> output_bit 1,0,1,1 at T+1..T+4 with bit_valid=1, done=1 at T+5, busy=0 at T+5.
REQ-033 SHALL verify: repeat_count=3 -> 12 contiguous valid bits 101110111011, then a single done pulse.
REQ-034 SHALL verify, with SEQGEN_PARITY_EN and repeat_count=2 -> 1011 1 1011 1 (10 valid bits), then done.
REQ-035 SHALL verify: repeat_count=0 -> done=1 at T+1, bit_valid never asserted, busy stays 0.
REQ-036 SHALL verify: start pulsed at T+2 during a transmission -> ignored, exactly 4 bits sent.
REQ-037 SHALL verify: reset asserted at T+2 mid-sequence -> all outputs 0 within the same cycle, no done; a new start then sends 1,0,1,1 from the MSB.
